load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 Pipeline side inputs SHALL be: mem_read  in  1  load in MEM stage (ResultSrc=01); MemWrite  in  1  store in MEM stage; s_sel  in  2  00 byte / 01 half / 10 word; l_sel  in  2  same encoding; u_load  in  1  1 = zero-extend; addr  in  32  byte address (ALUResultM); wdata  in  32  store data, LSB-justified.
REQ-003 Pipeline side outputs SHALL be: stall  out  1  freeze IF–MEM stages; rdata  out  32  extended load data; misalign  out  1  one-cycle misaligned-access flag.
REQ-004 Bus side SHALL be: req_valid  out  1; req_ready  in  1; req_we  out  1; req_addr  out  32  word-aligned (addr[1:0]=00); req_wstrb  out  4  byte enables; req_wdata  out  32  lane-shifted data; resp_valid  in  1; resp_rdata  in  32  full word.

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-006 IDLE: when mem_read or MemWrite is 1 (and the access is not misaligned under REQ-016), the block SHALL latch addr, wdata, s_sel/l_sel, u_load, and the access type, then move to REQ next cycle. If both are 1, the block SHALL treat the access as a store.
REQ-007 stall SHALL be combinational: 1 in IDLE with an access pending, and 1 in REQ and WAIT; 0 in DONE and otherwise.
REQ-008 REQ: req_valid SHALL be 1. req_we, req_addr, req_wstrb, and req_wdata SHALL remain stable until the cycle in which req_valid & req_ready both equal 1.
REQ-009 On handshake, a store SHALL go to DONE and a load SHALL go to WAIT. resp_valid SHALL be ignored outside WAIT.
REQ-010 WAIT: on resp_valid, the block SHALL register the extracted and extended word into rdata and go to DONE. With no resp_valid, it SHALL remain in WAIT indefinitely.
REQ-011 DONE: the block SHALL hold stall=0 for exactly one cycle, so the pipeline advances, then return to IDLE. DONE SHALL never re-launch the same access.
REQ-012 Store lanes: byte SHALL give wstrb = 0001<<addr[1:0] and data = {4{wdata[7:0]}}. Half SHALL give wstrb = 0011<<addr[1:0] and data = {2{wdata[15:0]}}. Word SHALL give wstrb = 1111 and data = wdata. s_sel=11 SHALL be treated as word.
REQ-013 Load extract: byte SHALL take resp_rdata[8*addr[1:0] +: 8]. Half SHALL take resp_rdata[16*addr[1] +: 16]. Word SHALL take the full word. Extension SHALL be zero when u_load=1 and sign otherwise. l_sel=11 SHALL be treated as word.
REQ-014 rdata SHALL hold its last value until the next load completes.
REQ-015 Minimum latency SHALL be: store 2 stall cycles (IDLE-detect, REQ with ready=1); load 3 stall cycles (resp_valid in the first WAIT cycle).

Reset
REQ-016 reset SHALL force IDLE, req_valid=0, req_we=0, req_wstrb=0000, req_addr=0, req_wdata=0, rdata=0, and misalign=0 on the next edge, including mid-REQ and mid-WAIT. A response arriving after reset SHALL be discarded.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠00, SHALL pulse misalign=1 for one cycle in IDLE, issue no bus request, and keep stall=0.
- Undefined: misalign SHALL be tied 0. Offending low address bits SHALL be ignored: half uses addr[1] and word uses offset 0.

Verification
REQ-018 Store byte: addr=0x1003, wdata=0x000000A5, s_sel=00, req_ready=1 -> req_addr=0x1000, wstrb=1000, req_wdata=0xA5A5A5A5, stall high for 2 cycles.
REQ-019 Signed byte load: addr=0x2001, l_sel=00, u_load=0, resp_rdata=0x1234_80FF in the first WAIT cycle -> rdata=0xFFFFFF80, stall for 3 cycles.
REQ-020 Unsigned half load with backpressure: addr=0x2002, l_sel=01, u_load=1, req_ready held low 4 cycles, resp_rdata=0xBEEF0000 -> request fields stable throughout, rdata=0x0000BEEF.
REQ-021 Reset mid-WAIT, then resp_valid arrives -> state IDLE, stall=0, rdata=0, response ignored.
REQ-022 Word store at addr=0x3002 -> with LSU_MISALIGN_TRAP_EN, misalign pulse and no req_valid; without it, req_addr=0x3000 and wstrb=1111.
REQ-023 Back-to-back load then store -> exactly two bus handshakes, and DONE never re-launches an access.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the MEM stage of an in-order pipeline to a valid/ready memory bus.
// A load or store seen in IDLE is latched and launched as one word-aligned bus
// request. The pipeline is stalled until the access finishes. Loads wait for
// resp_valid, extract and extend the addressed byte/half/word into rdata, and
// rdata then holds that value until the next load completes. DONE releases
// stall for exactly one cycle, which lets the pipeline retire the access.
//
// Optional feature (define LSU_MISALIGN_TRAP_EN to enable):
//   A misaligned half or word access pulses misalign for one cycle. It issues
//   no bus request and does not stall. When the macro is undefined, misalign
//   is tied 0 and the offending low address bits are ignored: a half access
//   uses only addr[1], and a word access always uses offset 0.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   mem_read, MemWrite      load / store request from the MEM stage
//                           (a store wins if both are set)
//   s_sel, l_sel            access size: 00 byte, 01 half, 1x word
//   u_load                  1 = zero-extend the load result, 0 = sign-extend
//   addr, wdata             byte address and LSB-justified store data
//   stall                   freezes the IF..MEM stages
//   rdata                   extended load data
//   misalign                one-cycle misaligned-access flag
//   req_valid/req_ready     bus request handshake
//   req_we                  bus write enable
//   req_addr                word-aligned bus address
//   req_wstrb               bus byte enables
//   req_wdata               lane-shifted store data
//   resp_valid, resp_rdata  load response; only used while in WAIT
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        MemWrite,
  input  logic [1:0]  s_sel,
  input  logic [1:0]  l_sel,
  input  logic        u_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [1:0]  l_sel_q, l_sel_d;
  logic        u_load_q, u_load_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic        access;
  logic        trap;
  logic        launch;

  // Store byte enables. A half access only uses addr[1]; a word access
  // ignores the offset.
  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate the store data across the lanes so that the strobes select it.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of the response word, then extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] off,
                                               input logic uns, input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w;
    r  = w;
    case (sz)
      2'b00: begin
        sh = w >> {off, 3'b000};
        r  = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = w >> {off[1], 4'b0000};
        r  = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

  assign trap = access & misaligned_f(MemWrite ? s_sel : l_sel, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign access = mem_read | MemWrite;
  // A trapped access never reaches the bus.
  assign launch = access & ~trap;

  // State register and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
    l_sel_q  <= l_sel_d;
    u_load_q <= u_load_d;
    off_q    <= off_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (launch)     state_d = REQ;
      REQ:  if (req_ready)  state_d = req_we_q ? DONE : WAIT;
      WAIT: if (resp_valid) state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Request capture in IDLE and load-data capture in WAIT. The request fields
  // only change in IDLE, so they stay stable through any REQ backpressure.
  always_comb begin
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    l_sel_d     = l_sel_q;
    u_load_d    = u_load_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    misalign_d  = 1'b0;
    if (state_q == IDLE) begin
      misalign_d = trap;
      if (launch) begin
        req_we_d    = MemWrite;
        req_addr_d  = {addr[31:2], 2'b00};
        req_wstrb_d = MemWrite ? store_strb(s_sel, addr[1:0]) : 4'b0000;
        req_wdata_d = MemWrite ? store_data(s_sel, wdata) : 32'h0;
        l_sel_d     = l_sel;
        u_load_d    = u_load;
        off_d       = addr[1:0];
      end
    end
    if (state_q == WAIT && resp_valid) begin
      rdata_d = load_extract(l_sel_q, off_q, u_load_q, resp_rdata);
    end
  end

  // Outputs
  always_comb begin
    req_valid = (state_q == REQ);
    stall     = ((state_q == IDLE) && launch) || (state_q == REQ) || (state_q == WAIT);
  end

  assign req_we    = req_we_q;
  assign req_addr  = req_addr_q;
  assign req_wstrb = req_wstrb_q;
  assign req_wdata = req_wdata_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;

endmodule
